multiplier_datapath: RTL and testbench
======================================

// Module: multiplier_datapath
// PURPOSE
//  Datapath of the unsigned shift-add multiplier; sits directly downstream of Control.
//  Holds the multiplicand register and the double-width product register, and performs one add-and-shift step per cycle.
//  Every step is commanded by Control's write/add strobes.
//  Feeds the product LSB back to Control (lsb) and presents the final product once Control raises rdy.
// PARAMETERS
//  WIDTH       32        operand width; product is 2*WIDTH bits
//  ADDU_FUNCT  6'b100001 addu_ctrl code that enables the adder; taken from the shared package
// PORTS
//  clk                  in   1        rising-edge clock, single domain
//  rst                  in   1        reset: synchronous, active-high
//  w_ctrl_Multiplicand  in   1        load strobe: captures the operands
//  adding_ctrl          in   1        add multiplicand into the upper product half on this step
//  addu_ctrl            in   6        adder operation code; only ADDU_FUNCT performs an add
//  w_ctrl_Product       in   1        step strobe: write (add/shift) the product register
//  multiplicand_in      in   WIDTH    operand A, sampled on load
//  multiplier_in        in   WIDTH    operand B, sampled on load
//  lsb                  out  1        product_reg[0]; drives Control's lsb input
//  product              out  2*WIDTH  product_reg[2*WIDTH-1:0]
// BEHAVIOUR
//  - Registers
//    - mcand_reg[WIDTH-1:0].
//    - product_reg[2*WIDTH:0]: one extra carry bit at the top.
//    - All state updates on the rising edge of clk only.
//  - rst=1 at an edge
//    - mcand_reg=0, product_reg=0, so lsb=0 and product=0 in the following cycle.
//    - Overrides every strobe, including mid-multiplication; no partial state survives.
//  - Load (w_ctrl_Multiplicand=1, rst=0)
//    - mcand_reg<=multiplicand_in.
//    - product_reg<={(WIDTH+1)'b0, multiplier_in}.
//    - Load wins over a simultaneous w_ctrl_Product; no step is taken that cycle.
//  - Step (w_ctrl_Product=1, no load, rst=0)
//    - hi = product_reg[2*WIDTH-1:WIDTH].
//    - sum[WIDTH:0] = (adding_ctrl && addu_ctrl==ADDU_FUNCT) ? {1'b0,hi}+{1'b0,mcand_reg} : {1'b0,hi}.
//    - product_reg <= {1'b0, sum, product_reg[WIDTH-1:1]}: add and right-shift in one cycle, carry shifted into the MSB.
//  - Non-ADDU code with adding_ctrl=1: no add, plain shift. No error flag.
//  - Idle (no strobe): all registers hold.
//  - Latency
//    - lsb and product are registered-outputs only (no combinational input->output path).
//    - Each reflects the step one cycle after the edge.
//    - After load + WIDTH steps, product = multiplicand_in*multiplier_in exactly (mod 2^(2*WIDTH), never truncated).
//  - Overflow/wrap: the carry bit guarantees no loss for any WIDTH-bit unsigned pair. Extra steps beyond WIDTH keep shifting right (datapath does not count).
//  - X-safety: strobes must be known after reset; operand inputs are sampled only on load.
// STRUCTURE
//  - Shared package mult_pkg: WIDTH default, ADDU_FUNCT, product width localparam PWIDTH=2*WIDTH. Control imports the same constants.
//  - One sub-module: mult_adder (WIDTH-bit unsigned adder, carry out; enabled by en and op==ADDU_FUNCT, else passes A through).
//  - Registers and step/shift muxing stay in multiplier_datapath.
// TESTING
//  - Reset: rst=1 for 2 cycles with strobes random -> lsb=0, product=0.
//  - 3 x 5: load, then 32 steps with adding_ctrl=lsb, addu_ctrl=ADDU_FUNCT -> product=64'h0000_0000_0000_000F; lsb after load=1.
//  - Carry: 32'hFFFF_FFFF x 32'hFFFF_FFFF, 32 steps -> product=64'hFFFF_FFFE_0000_0001.
//  - Bad opcode: load 7 x 1, addu_ctrl=6'b100011 with adding_ctrl=1, 1 step -> product=0 (pure shift, no add).
//  - Priority: load and w_ctrl_Product together -> operands loaded, no shift. rst asserted at step 10 of 12345 x 678 -> all zero next cycle; reload gives 8369910 after 32 steps.
//  - Closed loop with Control: run=1, operands 0xDEADBEEF x 0x10 -> product=64'h0000_000D_EADB_EEF0 when rdy=1.

Source files
------------

// File: rtl/multiplier_datapath_pkg.sv
// Shared constants for the shift-add multiplier (datapath and Control).
package mult_pkg;

  localparam int WIDTH  = 32;
  localparam int PWIDTH = 2 * WIDTH;

  typedef logic [5:0] funct_t;

  // Only this adder code performs an add; every other code passes through.
  localparam funct_t ADDU_FUNCT = 6'b100001;

endpackage : mult_pkg

// File: rtl/multiplier_datapath_if.sv
// Control <-> datapath bundle: step strobes and operands in, lsb/product back.
interface multiplier_datapath_if #(
  parameter int WIDTH = mult_pkg::WIDTH
);

  logic                 w_ctrl_Multiplicand;
  logic                 adding_ctrl;
  mult_pkg::funct_t     addu_ctrl;
  logic                 w_ctrl_Product;
  logic [WIDTH-1:0]     multiplicand_in;
  logic [WIDTH-1:0]     multiplier_in;
  logic                 lsb;
  logic [2*WIDTH-1:0]   product;

  // Control side.
  modport master (
    output w_ctrl_Multiplicand, adding_ctrl, addu_ctrl, w_ctrl_Product,
    output multiplicand_in, multiplier_in,
    input  lsb, product
  );

  // Datapath side.
  modport slave (
    input  w_ctrl_Multiplicand, adding_ctrl, addu_ctrl, w_ctrl_Product,
    input  multiplicand_in, multiplier_in,
    output lsb, product
  );

endinterface : multiplier_datapath_if

// File: rtl/multiplier_datapath_adder.sv
// WIDTH-bit unsigned adder with carry out; passes A through unless enabled
// with the ADDU code.
module mult_adder
  import mult_pkg::*;
#(
  parameter int WIDTH = mult_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             en_i,
  input  funct_t           op_i,
  output logic [WIDTH:0]   sum_o
);

  logic add_en;

  assign add_en = en_i && (op_i == ADDU_FUNCT);

  // Add with carry, or pass A zero-extended.
  always_comb begin
    sum_o = {1'b0, a_i};
    if (add_en) begin
      sum_o = {1'b0, a_i} + {1'b0, b_i};
    end
  end

endmodule : mult_adder

// File: rtl/multiplier_datapath.sv
// Shift-add multiplier datapath: multiplicand register plus double-width
// product register, one add-and-shift step per w_ctrl_Product strobe.
module multiplier_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = mult_pkg::WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  multiplier_datapath_if.slave dp
);

  localparam int PW = 2 * WIDTH;

  logic [WIDTH-1:0] mcand_q, mcand_d;
  // The adder carry lands in bit PW-1 after the right shift, so the
  // register above that column would always read zero and is not kept.
  logic [PW-1:0]    product_q, product_d;
  logic [WIDTH:0]   sum;

  mult_adder #(.WIDTH(WIDTH)) u_adder (
    .a_i   (product_q[PW-1:WIDTH]),
    .b_i   (mcand_q),
    .en_i  (dp.adding_ctrl),
    .op_i  (dp.addu_ctrl),
    .sum_o (sum)
  );

  // Next state: load has priority over step; otherwise hold.
  always_comb begin
    mcand_d   = mcand_q;
    product_d = product_q;
    if (dp.w_ctrl_Multiplicand) begin
      mcand_d   = dp.multiplicand_in;
      product_d = {{WIDTH{1'b0}}, dp.multiplier_in};
    end else if (dp.w_ctrl_Product) begin
      product_d = {sum, product_q[WIDTH-1:1]};
    end
  end

  // State registers with synchronous reset overriding every strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q   <= '0;
      product_q <= '0;
    end else begin
      mcand_q   <= mcand_d;
      product_q <= product_d;
    end
  end

  assign dp.lsb     = product_q[0];
  assign dp.product = product_q;

endmodule : multiplier_datapath

// File: tb/tb_multiplier_datapath.sv
// Directed plus randomized bench for multiplier_datapath with a behavioural
// multiply model.
module tb_multiplier_datapath;
  import mult_pkg::*;

  logic clk;
  logic rst;
  int   assert_cnt = 0;
  int   fail_cnt   = 0;

  multiplier_datapath_if #(.WIDTH(32)) dpi ();

  multiplier_datapath #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .dp  (dpi.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dpi.w_ctrl_Multiplicand = 1'b0;
    dpi.w_ctrl_Product      = 1'b0;
    dpi.adding_ctrl         = 1'b0;
    dpi.addu_ctrl           = ADDU_FUNCT;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] b);
    dpi.multiplicand_in     = a;
    dpi.multiplier_in       = b;
    dpi.w_ctrl_Multiplicand = 1'b1;
    dpi.w_ctrl_Product      = 1'b0;
    tick();
    dpi.w_ctrl_Multiplicand = 1'b0;
    dpi.multiplicand_in     = $urandom;
    dpi.multiplier_in       = $urandom;
  endtask

  // Behaves as Control would: add whenever the product LSB is set.
  task automatic run_steps(input int n);
    for (int i = 0; i < n; i++) begin
      dpi.adding_ctrl    = dpi.lsb;
      dpi.addu_ctrl      = ADDU_FUNCT;
      dpi.w_ctrl_Product = 1'b1;
      tick();
    end
    idle_inputs();
  endtask

  function automatic logic [63:0] mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wa, wb;
    wa = {32'b0, a};
    wb = {32'b0, b};
    return wa * wb;
  endfunction

  initial begin
    logic [31:0]  a, b;
    logic [63:0]  held;
    logic [127:0] p_model;
    logic [127:0] hi_model;
    logic         add_bit;

    rst = 1'b1;
    idle_inputs();
    dpi.multiplicand_in = '0;
    dpi.multiplier_in   = '0;

    // Reset with random strobes.
    for (int i = 0; i < 2; i++) begin
      dpi.w_ctrl_Multiplicand = 1'($urandom);
      dpi.w_ctrl_Product      = 1'($urandom);
      dpi.adding_ctrl         = 1'($urandom);
      dpi.multiplicand_in     = $urandom;
      dpi.multiplier_in       = $urandom;
      tick();
    end
    check("reset_product", dpi.product, 64'h0);
    check("reset_lsb", {63'b0, dpi.lsb}, 64'h0);
    rst = 1'b0;
    idle_inputs();
    tick();

    // 3 x 5
    load(32'd3, 32'd5);
    check("load_lsb_3x5", {63'b0, dpi.lsb}, 64'h1);
    check("load_prod_3x5", dpi.product, 64'h5);
    run_steps(32);
    check("prod_3x5", dpi.product, 64'h0000_0000_0000_000F);

    // Idle hold
    held = dpi.product;
    tick(); tick(); tick();
    check("idle_hold", dpi.product, 64'h0000_0000_0000_000F);

    // Carry case
    load(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_steps(32);
    check("prod_ffxff", dpi.product, 64'hFFFF_FFFE_0000_0001);

    // Extra step without add keeps shifting right.
    dpi.adding_ctrl    = 1'b0;
    dpi.w_ctrl_Product = 1'b1;
    tick();
    idle_inputs();
    check("extra_shift", dpi.product, 64'hFFFF_FFFE_0000_0001 >> 1);

    // Non-ADDU code: plain shift.
    load(32'd7, 32'd1);
    dpi.adding_ctrl    = 1'b1;
    dpi.addu_ctrl      = 6'b100011;
    dpi.w_ctrl_Product = 1'b1;
    tick();
    idle_inputs();
    check("bad_opcode", dpi.product, 64'h0);

    // Load wins over a simultaneous step.
    load(32'd11, 32'd13);
    dpi.multiplicand_in     = 32'd1000;
    dpi.multiplier_in       = 32'h1234_5679;
    dpi.w_ctrl_Multiplicand = 1'b1;
    dpi.w_ctrl_Product      = 1'b1;
    dpi.adding_ctrl         = 1'b1;
    tick();
    idle_inputs();
    check("load_priority", dpi.product, 64'h0000_0000_1234_5679);
    run_steps(32);
    check("load_priority_mul", dpi.product, mul(32'd1000, 32'h1234_5679));

    // Reset mid-multiplication.
    load(32'd12345, 32'd678);
    run_steps(10);
    rst                = 1'b1;
    dpi.w_ctrl_Product = 1'b1;
    dpi.adding_ctrl    = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    check("mid_reset_product", dpi.product, 64'h0);
    check("mid_reset_lsb", {63'b0, dpi.lsb}, 64'h0);
    load(32'd12345, 32'd678);
    run_steps(32);
    check("reload_12345x678", dpi.product, 64'd8369910);

    // Closed-loop DEADBEEF x 0x10.
    load(32'hDEAD_BEEF, 32'h10);
    run_steps(32);
    check("deadbeef_x10", dpi.product, 64'h0000_000D_EADB_EEF0);

    // Random operand pairs, closed loop.
    for (int k = 0; k < 8; k++) begin
      a = $urandom;
      b = $urandom;
      if (k == 0) a = 32'h0;
      if (k == 1) b = 32'h8000_0000;
      load(a, b);
      run_steps(32);
      check($sformatf("rand_mul_%0d", k), dpi.product, mul(a, b));
    end

    // Random add pattern per step, checked against an arithmetic model:
    // the product is (upper half + optional multiplicand) * 2^31 + lower half / 2.
    for (int k = 0; k < 4; k++) begin
      a = $urandom;
      b = $urandom;
      load(a, b);
      p_model = {96'b0, b};
      for (int s = 0; s < 6; s++) begin
        add_bit            = 1'($urandom);
        dpi.adding_ctrl    = add_bit;
        dpi.addu_ctrl      = ADDU_FUNCT;
        dpi.w_ctrl_Product = 1'b1;
        tick();
        hi_model = p_model / 128'h1_0000_0000;
        if (add_bit) hi_model = hi_model + {96'b0, a};
        p_model = hi_model * 128'h8000_0000 + (p_model % 128'h1_0000_0000) / 2;
        p_model = p_model % (128'h1 << 64);
      end
      idle_inputs();
      check($sformatf("rand_pattern_%0d", k), dpi.product, p_model[63:0]);
      check($sformatf("rand_pattern_lsb_%0d", k), {63'b0, dpi.lsb}, {63'b0, p_model[0]});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule : tb_multiplier_datapath
